// File: rtl/reduce_channel_pkg.sv
// Shared types, default parameters and helpers for the lane-parallel reduce channel.
package reduce_channel_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } rc_state_t;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_BIAS  = 2;

  // Number of pairwise adder levels needed to reduce `lanes` words to one.
  function automatic int unsigned stages(input int unsigned lanes);
    int unsigned n;
    int unsigned v;
    n = 0;
    v = lanes;
    while (v > 1) begin
      v = v >> 1;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: halves the lane count and carries valid/last/mode.
module adder_tree_level
  import reduce_channel_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned IN_LANES = DEF_LANES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic                            in_mode,
  input  logic [IN_LANES*WIDTH-1:0]       in_data,
  output logic                            out_valid,
  output logic                            out_last,
  output logic                            out_mode,
  output logic [(IN_LANES/2)*WIDTH-1:0]   out_data
);

  localparam int unsigned OUT_LANES = IN_LANES / 2;
  localparam int unsigned OUT_BITS  = OUT_LANES * WIDTH;

  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                mode_q, mode_d;
  logic [OUT_BITS-1:0] data_q, data_d;

  // Pairwise sums of adjacent lanes; sideband and data only advance on a valid beat.
  always_comb begin
    valid_d = in_valid;
    last_d  = last_q;
    mode_d  = mode_q;
    data_d  = data_q;
    if (in_valid) begin
      last_d = in_last;
      mode_d = in_mode;
      for (int unsigned i = 0; i < OUT_LANES; i++) begin
        data_d[i*WIDTH +: WIDTH] = in_data[(2*i)*WIDTH +: WIDTH]
                                 + in_data[(2*i+1)*WIDTH +: WIDTH];
      end
    end
  end

  // Level register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_mode  = mode_q;
  assign out_data  = data_q;

endmodule

// File: rtl/reduce_channel_adder_tree.sv
// Pipelined lane reducer: adder tree, then per-beat bias or per-packet accumulation.
module reduce_channel_adder_tree
  import reduce_channel_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned BIAS  = DEF_BIAS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   acc_mode,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [WIDTH-1:0]       result
);

  localparam int unsigned NSTG  = stages(LANES);
  localparam int unsigned NODES = 2 * LANES - 1;
  localparam logic [WIDTH-1:0] BIAS_W = WIDTH'(BIAS);

  // Tree nodes packed heap-style: level k occupies lanes [2L-2(L>>k), 2L-(L>>k)).
  logic [NODES*WIDTH-1:0] node_data;
  logic [NSTG:0]          node_valid;
  logic [NSTG:0]          node_last;
  logic [NSTG:0]          node_mode;

  assign node_data[LANES*WIDTH-1:0] = in_data;
  assign node_valid[0]              = in_valid;
  assign node_last[0]               = in_last;
  assign node_mode[0]               = acc_mode;

  for (genvar k = 0; k < NSTG; k++) begin : g_level
    localparam int unsigned IN_L    = LANES >> k;
    localparam int unsigned IN_OFF  = 2 * LANES - 2 * IN_L;
    localparam int unsigned OUT_OFF = 2 * LANES - IN_L;

    adder_tree_level #(
      .WIDTH    (WIDTH),
      .IN_LANES (IN_L)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (node_valid[k]),
      .in_last   (node_last[k]),
      .in_mode   (node_mode[k]),
      .in_data   (node_data[IN_OFF*WIDTH +: IN_L*WIDTH]),
      .out_valid (node_valid[k+1]),
      .out_last  (node_last[k+1]),
      .out_mode  (node_mode[k+1]),
      .out_data  (node_data[OUT_OFF*WIDTH +: (IN_L/2)*WIDTH])
    );
  end

  logic [WIDTH-1:0] tree_sum;
  logic             tree_valid;
  logic             tree_last;
  logic             tree_mode;

  assign tree_sum   = node_data[(NODES-1)*WIDTH +: WIDTH];
  assign tree_valid = node_valid[NSTG];
  assign tree_last  = node_last[NSTG];
  assign tree_mode  = node_mode[NSTG];

  rc_state_t        state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [WIDTH-1:0] acc_sum;

  // Final stage: bias per beat, or accumulate a packet seeded with the bias.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    acc_sum     = ((state_q == IDLE) ? BIAS_W : acc_q) + tree_sum;
    if (tree_valid) begin
      if (!tree_mode) begin
        // A per-beat result closes any open packet without emitting it.
        result_d    = tree_sum + BIAS_W;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end else begin
        acc_d = acc_sum;
        if (tree_last) begin
          result_d    = acc_sum;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
    end
  end

  // State, accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign result    = result_q;

endmodule

// File: tb/tb_reduce_channel_adder_tree.sv
// Self-checking bench: vector table plus hand sequences, scoreboard-checked outputs.
module tb_reduce_channel_adder_tree;

  localparam int unsigned W     = 16;
  localparam int unsigned L     = 4;
  localparam int unsigned B     = 2;
  localparam int unsigned LAT   = 3;
  localparam int unsigned NVEC  = 18;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b1;
  logic [L*W-1:0] in_data = '0;
  logic           in_last = 1'b0;
  logic           acc_mode = 1'b0;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   result;

  reduce_channel_adder_tree #(.WIDTH(W), .LANES(L), .BIAS(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .out_last  (out_last),
    .result    (result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         last;
    int           due;
  } sb_t;

  typedef struct packed {
    logic           vld;
    logic           mode;
    logic           last;
    logic [L*W-1:0] data;
    logic           exp_out;
    logic [W-1:0]   exp_res;
    logic           exp_last;
  } vec_t;

  sb_t    sb[$];
  sb_t    e;
  vec_t   vecs[NVEC];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  logic   rst_at_edge = 1'b0;
  logic [W-1:0] hold_exp = '0;
  logic         m_open = 1'b0;
  logic [W-1:0] m_acc = '0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  // Output monitor: pops expectations on out_valid, otherwise checks the held value.
  always @(negedge clk) begin
    if (rst_at_edge) begin
      sb.delete();
      hold_exp = '0;
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0 || result !== '0) begin
        errors++;
        $display("FAIL reset_out: got valid=%0b last=%0b res=%0h, want 0 0 0",
                 out_valid, out_last, result);
      end
    end else if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got res=%0h last=%0b at cyc %0d, want no output",
                 result, out_last, cyc);
      end else begin
        e = sb.pop_front();
        hold_exp = e.res;
        if (result !== e.res || out_last !== e.last || cyc != e.due) begin
          errors++;
          $display("FAIL output: got res=%0h last=%0b cyc=%0d, want res=%0h last=%0b cyc=%0d",
                   result, out_last, cyc, e.res, e.last, e.due);
        end
      end
    end else begin
      checks++;
      if (result !== hold_exp || out_last !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold: got res=%0h last=%0b valid=%0b, want res=%0h last=0 valid=0",
                 result, out_last, out_valid, hold_exp);
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out: got nothing by cyc %0d, want res=%0h due cyc %0d",
                 cyc, sb[0].res, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  function automatic logic [L*W-1:0] pack4(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c, input logic [W-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [W-1:0] lane_sum(input logic [L*W-1:0] d);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < L; i++) s = s + d[i*W +: W];
    return s;
  endfunction

  function automatic vec_t mk(input logic vld, input logic mode, input logic last,
                              input logic [L*W-1:0] data, input logic exp_out,
                              input logic [W-1:0] exp_res, input logic exp_last);
    vec_t v;
    v.vld = vld; v.mode = mode; v.last = last; v.data = data;
    v.exp_out = exp_out; v.exp_res = exp_res; v.exp_last = exp_last;
    return v;
  endfunction

  task automatic beat(input logic vld, input logic mode, input logic last,
                      input logic [L*W-1:0] data, input logic exp_out,
                      input logic [W-1:0] exp_res, input logic exp_last);
    sb_t s;
    @(negedge clk);
    in_valid = vld;
    acc_mode = mode;
    in_last  = last;
    in_data  = data;
    if (exp_out) begin
      s.res  = exp_res;
      s.last = exp_last;
      s.due  = cyc + LAT;
      sb.push_back(s);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      acc_mode = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      in_last  = 1'($urandom_range(0, 1));
      acc_mode = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    m_open   = 1'b0;
  endtask

  // Reference behaviour for the random section.
  task automatic model_beat(input logic vld, input logic mode, input logic last,
                            input logic [L*W-1:0] data);
    logic [W-1:0] s;
    s = lane_sum(data);
    if (!vld) begin
      beat(1'b0, mode, last, data, 1'b0, '0, 1'b0);
    end else if (!mode) begin
      m_open = 1'b0;
      beat(1'b1, 1'b0, last, data, 1'b1, W'(s + W'(B)), 1'b0);
    end else begin
      if (!m_open) m_acc = W'(B);
      m_acc = m_acc + s;
      if (last) begin
        m_open = 1'b0;
        beat(1'b1, 1'b1, 1'b1, data, 1'b1, m_acc, 1'b1);
      end else begin
        m_open = 1'b1;
        beat(1'b1, 1'b1, 1'b0, data, 1'b0, '0, 1'b0);
      end
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, pack4(1, 2, 3, 4),                 1, 16'd12,   0);
    vecs[1]  = mk(1, 0, 0, pack4(10, 0, 0, 0),                1, 16'd12,   0);
    vecs[2]  = mk(1, 0, 0, pack4(15, 0, 0, 0),                1, 16'd17,   0);
    vecs[3]  = mk(0, 0, 0, pack4(18, 0, 0, 0),                0, 16'd0,    0);
    vecs[4]  = mk(1, 1, 0, pack4(1, 1, 1, 1),                 0, 16'd0,    0);
    vecs[5]  = mk(1, 1, 0, pack4(1, 1, 1, 1),                 0, 16'd0,    0);
    vecs[6]  = mk(1, 1, 1, pack4(1, 1, 1, 1),                 1, 16'd14,   1);
    vecs[7]  = mk(1, 0, 0, pack4(16'hFFFF, 1, 0, 0),          1, 16'd2,    0);
    vecs[8]  = mk(1, 1, 0, pack4(16'h8000, 0, 0, 0),          0, 16'd0,    0);
    vecs[9]  = mk(1, 1, 1, pack4(16'h8000, 0, 0, 0),          1, 16'd2,    1);
    vecs[10] = mk(1, 1, 0, pack4(4, 0, 0, 0),                 0, 16'd0,    0);
    vecs[11] = mk(1, 0, 0, pack4(1, 0, 0, 0),                 1, 16'd3,    0);
    vecs[12] = mk(1, 1, 1, pack4(5, 0, 0, 0),                 1, 16'd7,    1);
    vecs[13] = mk(1, 0, 0, pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                                                              1, 16'hFFFE, 0);
    vecs[14] = mk(1, 0, 1, pack4(0, 0, 0, 0),                 1, 16'd2,    0);
    vecs[15] = mk(1, 1, 0, pack4(7, 0, 0, 0),                 0, 16'd0,    0);
    vecs[16] = mk(0, 1, 1, pack4(100, 0, 0, 0),               0, 16'd0,    0);
    vecs[17] = mk(1, 1, 1, pack4(0, 0, 0, 3),                 1, 16'd12,   1);

    // Reset held with live random beats, then quiet cycles.
    do_reset(2);
    idle(3);

    // Table: back-to-back beats, expected outputs from hand-computed constants.
    for (int i = 0; i < NVEC; i++) begin
      beat(vecs[i].vld, vecs[i].mode, vecs[i].last, vecs[i].data,
           vecs[i].exp_out, vecs[i].exp_res, vecs[i].exp_last);
    end
    idle(6);

    // Reset while a packet is open discards it.
    beat(1, 1, 0, pack4(1, 0, 0, 0), 0, '0, 0);
    beat(1, 1, 0, pack4(2, 0, 0, 0), 0, '0, 0);
    idle(4);
    do_reset(1);
    beat(1, 1, 1, pack4(5, 0, 0, 0), 1, 16'd7, 1);
    idle(5);

    // A beat still in the pipe when reset hits never emerges.
    beat(1, 0, 0, pack4(9, 0, 0, 0), 0, '0, 0);
    do_reset(1);
    idle(5);

    // Random mix checked against the reference model.
    for (int i = 0; i < 60; i++) begin
      model_beat(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), {$urandom, $urandom});
    end
    idle(8);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outputs pending, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
